// File: rtl/rv32i_types.sv
// Shared RV32I core types: the common-data-bus broadcast record and the default
// number of functional units that share it.
package rv32i_types;

    localparam int NUM_FU_DEFAULT = 4;
    localparam int ROB_IDX_W      = 6;

    typedef struct packed {
        logic                 ready;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [4:0]           rd;
        logic [31:0]          result;
    } cdb_t;

    // Index wrap for a circular scan; idx is never more than 2*n-2.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Purely combinational round-robin picker: scans the request vector upward from
// ptr with wrap and returns a one-hot grant for the first requester found.
module rr_priority_pick
    import rv32i_types::*;
#(
    parameter  int N  = NUM_FU_DEFAULT,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == rr_wrap(int'(ptr) + k, N))) begin
                    gnt[i] = 1'b1;
                end
            end
            found = found | (|gnt);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one functional unit per cycle round-robin and
// registers the winner's broadcast; losers are stalled and hold their data.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter  int NUM_FU = NUM_FU_DEFAULT,
    localparam int IDW    = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              rst,
    input  cdb_t              fu_cdb [NUM_FU],
    input  logic              flush,
    output logic [NUM_FU-1:0] fu_stall,
    output cdb_t              cdb_out,
    output logic [IDW-1:0]    grant_id,
    output logic [31:0]       conflict_cnt
);

    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] gnt;
    logic [IDW-1:0]    gnt_idx;
    cdb_t              cdb_sel;

    cdb_t              cdb_out_q,      cdb_out_d;
    logic [IDW-1:0]    grant_id_q,     grant_id_d;
    logic [IDW-1:0]    rr_ptr_q,       rr_ptr_d;
    logic [31:0]       conflict_cnt_q, conflict_cnt_d;

    // Flush and reset both mask every request, so nothing is granted or stalled.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            req[i] = fu_cdb[i].ready & ~flush & ~rst;
        end
    end

    rr_priority_pick #(.N(NUM_FU)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        cdb_sel = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDW'(i);
                cdb_sel = fu_cdb[i];
            end
        end
    end

    assign fu_stall = req & ~gnt;

    always_comb begin
        cdb_out_d       = cdb_sel;
        cdb_out_d.ready = |gnt;
        grant_id_d      = gnt_idx;
        rr_ptr_d        = rr_ptr_q;
        if (|gnt) begin
            rr_ptr_d = (gnt_idx == IDW'(NUM_FU - 1)) ? '0 : gnt_idx + IDW'(1);
        end
        conflict_cnt_d = conflict_cnt_q + ((|fu_stall) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_out_q      <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            cdb_out_q      <= cdb_out_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cdb_out      = cdb_out_q;
    assign grant_id     = grant_id_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then a
// long random run compared every cycle against a behavioural arbitration model.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          flush;
    cdb_t          fu_cdb [N];
    logic [N-1:0]  fu_stall;
    cdb_t          cdb_out;
    logic [IW-1:0] grant_id;
    logic [31:0]   conflict_cnt;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .fu_cdb       (fu_cdb),
        .flush        (flush),
        .fu_stall     (fu_stall),
        .cdb_out      (cdb_out),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the winner is the first ready FU met when walking upward
    // from the pointer; its record reappears on the bus one cycle later.
    bit           started = 1'b0;
    bit           exp_valid;
    int           exp_gid;
    cdb_t         exp_cdb;
    logic [31:0]  exp_cnt;
    logic [N-1:0] exp_stall = '0;
    int           m_ptr;
    int           dut_run [N];

    always @(negedge clk) begin
        int           g;
        int           idx;
        logic [N-1:0] rdy;
        if (started) begin
            chk("cdb_ready", 64'(cdb_out.ready), 64'(exp_valid));
            if (exp_valid) begin
                chk("cdb_data", 64'(cdb_out), 64'(exp_cdb));
                chk("grant_id", 64'(grant_id), 64'(exp_gid));
            end
            chk("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
        end
        rdy = '0;
        for (int i = 0; i < N; i++) rdy[i] = fu_cdb[i].ready;
        if (rst) begin
            exp_stall = '0;
            exp_valid = 1'b0;
            exp_cnt   = '0;
            m_ptr     = 0;
            started   = 1'b1;
        end else if (flush) begin
            exp_stall = '0;
            exp_valid = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && rdy[IW'(idx)]) g = idx;
            end
            exp_stall = rdy;
            exp_valid = 1'b0;
            if (g >= 0) begin
                exp_stall[IW'(g)] = 1'b0;
                exp_valid         = 1'b1;
                exp_cdb           = fu_cdb[IW'(g)];
                exp_gid           = g;
                m_ptr             = (g + 1) % N;
            end
            if (|exp_stall) exp_cnt = exp_cnt + 32'd1;
        end
        if (started) begin
            chk("fu_stall", 64'(fu_stall), 64'(exp_stall));
            for (int i = 0; i < N; i++) begin
                dut_run[i] = fu_stall[i] ? dut_run[i] + 1 : 0;
                if (fu_stall[i]) chk("stall_run_bound", 64'(dut_run[i] < N), 64'(1));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input bit rdy, input logic [31:0] res);
        fu_cdb[i].ready   = rdy;
        fu_cdb[i].result  = res;
        fu_cdb[i].rob_idx = 6'(i + 8);
        fu_cdb[i].rd      = 5'(i + 1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_fu(i, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clear_all();
        next_cycle();
        for (int i = 0; i < N; i++) set_fu(i, 1'b1, 32'h55 + i);
        @(negedge clk);
        chk("reset_stall", 64'(fu_stall), 64'(0));
        chk("reset_ready", 64'(cdb_out.ready), 64'(0));
        chk("reset_gid", 64'(grant_id), 64'(0));
        chk("reset_cnt", 64'(conflict_cnt), 64'(0));
        next_cycle();
        rst = 1'b0;
        clear_all();

        // FU0 and FU2 collide right after reset.
        set_fu(0, 1'b1, 32'hA0);
        set_fu(2, 1'b1, 32'hA2);
        @(negedge clk);
        chk("t27_stall", 64'(fu_stall), 64'(4'b0100));
        next_cycle();
        set_fu(0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t27_c2_ready", 64'(cdb_out.ready), 64'(1));
        chk("t27_c2_result", 64'(cdb_out.result), 64'(32'hA0));
        chk("t27_c2_gid", 64'(grant_id), 64'(0));
        chk("t27_c2_stall", 64'(fu_stall), 64'(0));
        next_cycle();
        set_fu(2, 1'b0, 32'h0);
        @(negedge clk);
        chk("t27_c3_result", 64'(cdb_out.result), 64'(32'hA2));
        chk("t27_c3_gid", 64'(grant_id), 64'(2));
        chk("t27_cnt", 64'(conflict_cnt), 64'(1));
        next_cycle();

        // All four FUs request continuously.
        do_reset();
        for (int i = 0; i < N; i++) set_fu(i, 1'b1, 32'h100 + i);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("t28_first_stall", 64'(fu_stall), 64'(4'b1110));
            if (c > 0) chk("t28_order", 64'(grant_id), 64'(order[c-1]));
            next_cycle();
        end
        clear_all();
        @(negedge clk);
        chk("t28_order_last", 64'(grant_id), 64'(order[7]));
        next_cycle();

        // Lone FU0 streams five results back to back.
        for (int k = 1; k <= 5; k++) begin
            set_fu(0, 1'b1, 32'(k));
            @(negedge clk);
            chk("t29_stall", 64'(fu_stall), 64'(0));
            if (k > 1) chk("t29_result", 64'(cdb_out.result), 64'(k - 1));
            next_cycle();
        end
        clear_all();
        @(negedge clk);
        chk("t29_ready_last", 64'(cdb_out.ready), 64'(1));
        chk("t29_result_last", 64'(cdb_out.result), 64'(5));
        next_cycle();

        // Flush kills arbitration for one cycle and leaves the pointer alone.
        do_reset();
        set_fu(1, 1'b1, 32'h31);
        set_fu(3, 1'b1, 32'h33);
        flush = 1'b1;
        @(negedge clk);
        chk("t30_flush_stall", 64'(fu_stall), 64'(0));
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("t30_ready", 64'(cdb_out.ready), 64'(0));
        chk("t30_stall", 64'(fu_stall), 64'(4'b1000));
        next_cycle();
        set_fu(1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t30_gid", 64'(grant_id), 64'(1));
        chk("t30_result", 64'(cdb_out.result), 64'(32'h31));
        next_cycle();
        set_fu(3, 1'b0, 32'h0);
        @(negedge clk);
        chk("t30_gid_second", 64'(grant_id), 64'(3));
        next_cycle();

        // Reset right after a grant to FU2.
        do_reset();
        set_fu(2, 1'b1, 32'h42);
        @(negedge clk);
        chk("t31_grant_stall", 64'(fu_stall), 64'(0));
        next_cycle();
        rst = 1'b1;
        set_fu(1, 1'b1, 32'h41);
        set_fu(2, 1'b1, 32'h52);
        @(negedge clk);
        chk("t31_rst_stall", 64'(fu_stall), 64'(0));
        chk("t31_pre_gid", 64'(grant_id), 64'(2));
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t31_ready", 64'(cdb_out.ready), 64'(0));
        chk("t31_cnt", 64'(conflict_cnt), 64'(0));
        chk("t31_stall", 64'(fu_stall), 64'(4'b0100));
        next_cycle();
        set_fu(1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t31_gid", 64'(grant_id), 64'(1));
        next_cycle();
        clear_all();
        @(negedge clk);
        chk("t31_gid_second", 64'(grant_id), 64'(2));
        next_cycle();

        // Random traffic; stalled FUs hold their record as the protocol requires.
        for (int c = 0; c < 10000; c++) begin
            rst   = ($urandom_range(0, 1999) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                if (!exp_stall[i]) begin
                    fu_cdb[i].ready   = ($urandom_range(0, 99) < 55);
                    fu_cdb[i].rob_idx = 6'($urandom);
                    fu_cdb[i].rd      = 5'($urandom);
                    fu_cdb[i].result  = $urandom;
                end
            end
            next_cycle();
        end
        rst   = 1'b0;
        flush = 1'b0;
        clear_all();
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit requesters sharing the common data bus (2..8).
REQ-002 clk  input  1  single clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 fu_cdb  input  cdb_t[NUM_FU]  per-FU broadcast; fu_cdb[i].ready=1 means a request is valid; index 0 is the base ALU.
REQ-005 fu_stall  output  NUM_FU  per-FU stall; while 1 the FU holds fu_cdb[i] stable and accepts no new issue.
REQ-006 flush  input  1  pipeline flush (mispredict); kills the in-flight broadcast.
REQ-007 cdb_out  output  cdb_t  registered broadcast to ROB, RAT and reservation stations.
REQ-008 grant_id  output  $clog2(NUM_FU)  index of the FU whose data is in cdb_out; valid only when cdb_out.ready=1.
REQ-009 conflict_cnt  output  32  count of cycles in which at least one request was stalled.

Function
REQ-010 Each cycle the block SHALL grant at most one requester, selected round-robin starting at pointer rr_ptr and ascending with wrap from NUM_FU-1 to 0.
REQ-011 fu_stall[i] SHALL be combinational: fu_cdb[i].ready AND NOT granted[i]; requesters with ready=0 are never stalled.
REQ-012 A granted request SHALL appear on cdb_out exactly 1 cycle later: all fields copied unchanged, cdb_out.ready=1, grant_id=granted index.
REQ-013 With no requests, the next-cycle cdb_out.ready SHALL be 0; the other fields are don't-care.
REQ-014 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_FU; with no grant, rr_ptr is unchanged.
REQ-015 With a single requester, that requester SHALL be granted in the same cycle (no bubble), regardless of rr_ptr.
REQ-016 Back-to-back requests from one FU with no competition SHALL be broadcast on consecutive cycles, giving full throughput.
REQ-017 flush=1 SHALL force the next-cycle cdb_out.ready to 0, force all fu_stall to 0 that cycle, and grant nothing; rr_ptr is held.
REQ-018 Starvation bound: a continuously asserted request SHALL be granted within NUM_FU cycles.
REQ-019 conflict_cnt SHALL increment by 1 in each non-flush cycle where any fu_stall bit is 1; it wraps at 2^32.
REQ-020 No input field other than .ready SHALL affect arbitration.

Reset
REQ-021 On rst=1 at a clock edge: cdb_out.ready=0, grant_id=0, rr_ptr=0, conflict_cnt=0.
REQ-022 During the reset cycle fu_stall SHALL be all 0 and no grant is recorded.
REQ-023 Reset asserted mid-stream SHALL drop any pending broadcast; the first grant after reset starts at index 0.

Structure
REQ-024 cdb_t and NUM_FU_DEFAULT SHALL live in the shared rv32i_types package; no new typedefs are local to this module.
REQ-025 The round-robin selection SHALL be one sub-module, rr_priority_pick (request vector + pointer in, one-hot grant out, purely combinational).
REQ-026 The output stage SHALL be the only cdb_t register; there is no buffering per FU, because FUs hold their data under stall.

Verification
REQ-027 After reset, FU0 and FU2 request in cycle 1 → FU0 is granted and FU2 stalls; cycle 2 shows cdb_out from FU0 with grant_id=0; FU2 is broadcast in cycle 3; conflict_cnt=1.
REQ-028 All 4 FUs request continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; each FU is stalled ≤3 cycles in a row.
REQ-029 FU0 alone requests in cycles 1–5 with result=1..5 → cdb_out.result=1..5 in cycles 2–6; fu_stall stays 0.
REQ-030 FU1 and FU3 request with flush=1 in cycle 4 → cdb_out.ready=0 in cycle 5; in cycle 5 FU1 is granted, since rr_ptr was held at its pre-flush value.
REQ-031 rst is asserted in the cycle after a grant to FU2 → cdb_out.ready=0 and conflict_cnt=0 next cycle; with FU1 and FU2 then requesting, FU1 is granted first.
REQ-032 Randomized 10k-cycle run with a scoreboard: every request is broadcast exactly once, fields match, and no wait exceeds NUM_FU cycles.
